// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_e       : controller state encoding (2-bit binary)
//   DEFAULT_WIDTH : default operand/sum width in bits
package serial_adder_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fa_bit_cell.sv
// One-bit full adder; purely combinational.
//   x, y : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out (majority of x, y, ci)
module fa_bit_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder. Operands are captured on an accepted start and fed
// LSB-first through a single full-adder cell, one bit per clock. The result is
// published on the last RUN edge and a one-cycle done pulse follows.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : begin an addition (accepted in IDLE or DONE)
//   a, b  : operands, captured on accepted start
//   cin   : carry-in, captured on accepted start
//   busy  : high while bits are being processed
//   done  : one-cycle pulse, sum/cout valid from this cycle
//   sum   : result, held until the next completed addition
//   cout  : final carry-out, held with sum
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Holds the WIDTH-1 already-computed sum bits; the final bit comes straight
    // from the cell on the last edge.
    logic [WIDTH-2:0] s_sh_q, s_sh_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_s, fa_co;
    logic [WIDTH-1:0] s_cat;
    logic             last_bit;

    fa_bit_cell u_fa (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .ci (c_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters from the MSB side.
    assign s_cat    = {fa_s, s_sh_q};
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                s_sh_d = s_cat[WIDTH-1:1];
                c_d    = fa_co;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                if (last_bit) begin
                    sum_d   = s_cat;
                    cout_d  = fa_co;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus randomized
// operations against an arithmetic reference ({cout,sum} = a + b + cin).
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_tests;
    int n_fail;

    // Reference: last completed result as seen on the outputs.
    logic [W:0] prev_res;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT in IDLE or DONE. Returns at the negedge
    // of the done cycle with start deasserted. With noise set, start is held
    // high with other operands throughout RUN.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tci,
                         input logic noise);
        logic [W:0] expv;
        expv  = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tci};
        a     = ta;
        b     = tb_v;
        cin   = tci;
        start = 1'b1;
        @(negedge clk);
        // Accepted at E0; scramble inputs to show they are no longer observed.
        start = noise;
        a     = noise ? 8'h11 : W'($urandom);
        b     = noise ? 8'h22 : W'($urandom);
        cin   = 1'($urandom);
        for (int k = 0; k < W; k++) begin
            check_eq("busy_run", 64'(busy), 64'd1);
            check_eq("done_run", 64'(done), 64'd0);
            check_eq("sum_hold", 64'({cout, sum}), 64'(prev_res));
            @(negedge clk);
        end
        start = 1'b0;
        check_eq("done_pulse", 64'(done), 64'd1);
        check_eq("busy_done", 64'(busy), 64'd0);
        check_eq("result", 64'({cout, sum}), 64'(expv));
        prev_res = expv;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        prev_res = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_sum", 64'(sum), 64'd0);
        check_eq("rst_cout", 64'(cout), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_busy", 64'(busy), 64'd0);

        // Basic additions.
        do_op(8'h5A, 8'h33, 1'b0, 1'b0);
        check_eq("res_5a33", 64'({cout, sum}), 64'h08D);
        @(negedge clk);
        check_eq("done_once", 64'(done), 64'd0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        check_eq("res_ff01", 64'({cout, sum}), 64'h100);
        @(negedge clk);
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        check_eq("res_ffff1", 64'({cout, sum}), 64'h1FF);
        @(negedge clk);

        // start re-asserted during RUN is ignored.
        do_op(8'h5A, 8'h33, 1'b0, 1'b1);
        check_eq("res_noise", 64'({cout, sum}), 64'h08D);
        // Back-to-back from DONE: no IDLE gap, old result visible until done.
        do_op(8'h01, 8'h02, 1'b0, 1'b0);
        check_eq("res_b2b", 64'({cout, sum}), 64'h003);
        @(negedge clk);
        check_eq("b2b_done_once", 64'(done), 64'd0);
        check_eq("b2b_idle_busy", 64'(busy), 64'd0);

        // Reset in the middle of RUN.
        a     = 8'h5A;
        b     = 8'h33;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_done", 64'(done), 64'd0);
        check_eq("arst_sum", 64'(sum), 64'd0);
        check_eq("arst_cout", 64'(cout), 64'd0);
        prev_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            check_eq("post_rst_done", 64'(done), 64'd0);
        end
        do_op(8'h10, 8'h20, 1'b0, 1'b0);
        check_eq("res_1020", 64'({cout, sum}), 64'h030);

        // Randomized operations with random gaps (0 = back-to-back).
        for (int n = 0; n < 1000; n++) begin
            int gap;
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check_eq("gap_done", 64'(done), 64'd0);
                check_eq("gap_busy", 64'(busy), 64'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
